// File: rtl/pipe_adder.sv
// Pipelined ripple-chunk adder/subtractor, CHUNK bits per stage; optional OVF port under PIPE_ADDER_OVF_EN.
// Latency: STAGES = WIDTH/CHUNK cycles. Backpressure: a held output (out_valid && !out_ready) freezes every stage.
// Valid/ready handshake on both sides; full-rate when downstream is ready, bubbles carried by per-stage valid bits.
module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);
    localparam int STAGES = WIDTH / CHUNK;

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
    end

    logic adv;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Operands shrink by one chunk per stage: only the not-yet-added bits travel on.
        localparam int WIN = WIDTH - k * CHUNK;

        logic [WIN-1:0]   a_in;
        logic [WIN-1:0]   b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [CHUNK:0]   part;
        logic [WIDTH-1:0] s_nx;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_head
            assign a_in = A;
            assign b_in = sub ? ~B : B;
            assign c_in = sub | Cin;
            assign v_in = in_valid;
            assign s_in = '0;
        end else begin : g_body
            assign a_in = g_st[k-1].g_fwd.a_q;
            assign b_in = g_st[k-1].g_fwd.b_q;
            assign c_in = g_st[k-1].c_q;
            assign v_in = g_st[k-1].v_q;
            assign s_in = g_st[k-1].s_q;
        end

        assign part = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, c_in};

        always_comb begin
            s_nx = s_in;
            s_nx[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= part[CHUNK];
                s_q <= s_nx;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIN-CHUNK-1:0] a_q;
            logic [WIN-CHUNK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[WIN-1:CHUNK];
                    b_q <= b_in[WIN-1:CHUNK];
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        // In the last stage the operand slice holds the original sign bits (B already inverted for sub).
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (a_in[CHUNK-1] == b_in[CHUNK-1]) && (part[CHUNK-1] != a_in[CHUNK-1]);
                end
            end
        end
`endif
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign SUM       = g_st[STAGES-1].s_q;
    assign Cout      = g_st[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
    assign OVF       = g_st[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
